// File: rtl/calc_ctrl.sv
// Sequenced 16-bit calculator: single-cycle ALU ops, 16-step shift-add multiply and
// restoring divide, with the result streamed out high byte first under ready/valid.
module calc_ctrl (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] num1,
   input  logic [15:0] num2,
   input  logic [3:0]  op,
   input  logic        out_ready,
   output logic [7:0]  out,
   output logic        out_valid,
   output logic        busy,
   output logic        err,
   output logic        done
);

   // state  | meaning
   // IDLE   | waiting for start
   // EXEC   | one-cycle ALU op (ADD/SUB/AND/OR/XOR)
   // ITER   | 16 iterations of multiply or divide
   // OUT_HI | presenting result[15:8]
   // OUT_LO | presenting result[7:0], done on acceptance
   typedef enum logic [2:0] {IDLE, EXEC, ITER, OUT_HI, OUT_LO} state_t;

   state_t      state, state_nxt;
   logic [15:0] opa, opb, acc, result;
   logic [3:0]  op_r, cnt;
   logic        err_r;

   logic        start_ok, illegal, div_zero;
   logic [15:0] alu_res, mul_acc_nxt, div_rem_nxt, div_q_nxt;
   logic [16:0] div_shift, div_diff;
   logic        div_neg;

   assign start_ok = (state == IDLE) && start;
   assign illegal  = op[3];
   assign div_zero = ((op == 4'd6) || (op == 4'd7)) && (num2 == 16'h0000);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (illegal || div_zero)   state_nxt = OUT_HI;
               else if (op <= 4'd4)       state_nxt = EXEC;
               else                       state_nxt = ITER;
            end
         end
         EXEC:    state_nxt = OUT_HI;
         ITER:    if (cnt == 4'd15) state_nxt = OUT_HI;
         OUT_HI:  if (out_ready) state_nxt = OUT_LO;
         OUT_LO:  if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      out_valid = (state == OUT_HI) || (state == OUT_LO);
      busy      = (state != IDLE);
      done      = (state == OUT_LO) && out_ready;
      err       = out_valid ? err_r : 1'b0;
      out       = 8'h00;
      if (state == OUT_HI)      out = result[15:8];
      else if (state == OUT_LO) out = result[7:0];
   end

   always_comb begin
      case (op_r)
         4'd0:    alu_res = opa + opb;
         4'd1:    alu_res = opa - opb;
         4'd2:    alu_res = opa & opb;
         4'd3:    alu_res = opa | opb;
         4'd4:    alu_res = opa ^ opb;
         default: alu_res = 16'h0000;
      endcase
   end

   // Multiply: opa shifts left, opb right; divide: opa shifts the dividend out MSB
   // first while collecting quotient bits, acc holds the partial remainder.
   assign mul_acc_nxt = acc + (opb[0] ? opa : 16'h0000);
   assign div_shift   = {acc, opa[15]};
   assign div_diff    = div_shift - {1'b0, opb};
   assign div_neg     = div_diff[16];
   assign div_rem_nxt = div_neg ? div_shift[15:0] : div_diff[15:0];
   assign div_q_nxt   = {opa[14:0], ~div_neg};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         opa    <= 16'h0000;
         opb    <= 16'h0000;
         acc    <= 16'h0000;
         result <= 16'h0000;
         op_r   <= 4'd0;
         cnt    <= 4'd0;
         err_r  <= 1'b0;
      end else if (start_ok) begin
         op_r <= op;
         cnt  <= 4'd0;
         if (illegal) begin
            result <= 16'h0000;
            err_r  <= 1'b1;
         end else if (div_zero) begin
            result <= 16'hFFFF;
            err_r  <= 1'b1;
         end else begin
            opa   <= num1;
            opb   <= num2;
            acc   <= 16'h0000;
            err_r <= 1'b0;
         end
      end else if (state == EXEC) begin
         result <= alu_res;
      end else if (state == ITER) begin
         cnt <= cnt + 4'd1;
         if (op_r == 4'd5) begin
            acc <= mul_acc_nxt;
            opa <= {opa[14:0], 1'b0};
            opb <= {1'b0, opb[15:1]};
         end else begin
            acc <= div_rem_nxt;
            opa <= div_q_nxt;
         end
         if (cnt == 4'd15) begin
            if (op_r == 4'd5)      result <= mul_acc_nxt;
            else if (op_r == 4'd6) result <= div_q_nxt;
            else                   result <= div_rem_nxt;
         end
      end
   end

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl: stimulus pushes expected bytes into a queue, a monitor
// pops and compares on every accepted output byte.
module tb_calc_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] num1 = 16'h0000;
   logic [15:0] num2 = 16'h0000;
   logic [3:0]  op = 4'd0;
   logic        out_ready = 1'b1;
   logic [7:0]  out;
   logic        out_valid, busy, err, done;

   typedef struct {
      logic [7:0] b;
      logic       e;
      logic       d;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   calc_ctrl dut (
      .clock(clock), .reset(reset), .start(start), .num1(num1), .num2(num2), .op(op),
      .out_ready(out_ready), .out(out), .out_valid(out_valid), .busy(busy), .err(err),
      .done(done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (reset) begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_byte", {23'd0, 1'b1, out}, 32'd0);
            end else begin
               exp_t x;
               x = q.pop_front();
               chk("out_byte", out, x.b);
               chk("out_err", err, x.e);
               chk("out_done", done, x.d);
            end
         end else if (!out_valid) begin
            chk("out_zero_when_invalid", out, 8'h00);
            chk("done_without_valid", done, 1'b0);
         end
      end
   end

   task automatic push_res(input logic [15:0] r, input logic e);
      q.push_back('{b: r[15:8], e: e, d: 1'b0});
      q.push_back('{b: r[7:0],  e: e, d: 1'b1});
   endtask

   task automatic wait_done();
      int g;
      g = 0;
      while (!done && g < 40) begin
         @(negedge clock);
         g++;
      end
      chk("done_seen", done, 1'b1);
      @(negedge clock);
   endtask

   // Called at a negedge with the DUT idle; start is sampled at the next posedge.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] o,
                         input logic [15:0] r, input logic e, input int lat_exp,
                         input logic inject);
      int lat;
      push_res(r, e);
      num1 = a; num2 = b; op = o; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         if (inject && lat == 5) begin
            start = 1'b1; num1 = 16'hAAAA; num2 = 16'h5555; op = 4'd0;
         end else begin
            start = 1'b0;
         end
         @(negedge clock);
         lat++;
      end
      start = 1'b0;
      chk("latency", lat, lat_exp);
      wait_done();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      #1;
      chk("rst_out", out, 8'h00);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_done", done, 1'b0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;

      run_op(16'h1234, 16'h0FF0, 4'd0, 16'h2224, 1'b0, 2, 1'b0);
      run_op(16'h0005, 16'h0007, 4'd1, 16'hFFFE, 1'b0, 2, 1'b0);
      run_op(16'hF0F0, 16'h3C3C, 4'd2, 16'h3030, 1'b0, 2, 1'b0);
      run_op(16'h1200, 16'h0034, 4'd3, 16'h1234, 1'b0, 2, 1'b0);
      run_op(16'hFFFF, 16'h1234, 4'd4, 16'hEDCB, 1'b0, 2, 1'b0);
      run_op(16'h0123, 16'h0010, 4'd5, 16'h1230, 1'b0, 17, 1'b0);
      run_op(16'hFFFF, 16'h0002, 4'd5, 16'hFFFE, 1'b0, 17, 1'b0);
      run_op(16'h00FF, 16'h00FF, 4'd5, 16'hFE01, 1'b0, 17, 1'b0);
      run_op(16'h0064, 16'h0007, 4'd6, 16'h000E, 1'b0, 17, 1'b0);
      run_op(16'h0064, 16'h0007, 4'd7, 16'h0002, 1'b0, 17, 1'b0);
      run_op(16'hFFFF, 16'h0001, 4'd6, 16'hFFFF, 1'b0, 17, 1'b0);
      run_op(16'h1234, 16'h0000, 4'd6, 16'hFFFF, 1'b1, 1, 1'b0);
      run_op(16'h1234, 16'h0000, 4'd7, 16'hFFFF, 1'b1, 1, 1'b0);
      run_op(16'h1234, 16'h5678, 4'hA, 16'h0000, 1'b1, 1, 1'b0);
      run_op(16'h0123, 16'h0010, 4'd5, 16'h1230, 1'b0, 17, 1'b1);

      // Backpressure on the high byte
      push_res(16'h2224, 1'b0);
      out_ready = 1'b0;
      num1 = 16'h1234; num2 = 16'h0FF0; op = 4'd0; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      for (int i = 0; i < 5; i++) begin
         chk("bp_out", out, 8'h22);
         chk("bp_err", err, 1'b0);
         chk("bp_busy", busy, 1'b1);
         chk("bp_done", done, 1'b0);
         @(negedge clock);
      end
      out_ready = 1'b1;
      wait_done();

      // Reset at ITER count 7 aborts the multiply
      num1 = 16'h0123; num2 = 16'h0010; op = 4'd5; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int i = 1; i < 8; i++) @(negedge clock);
      reset = 1'b0;
      #1;
      chk("mid_rst_out", out, 8'h00);
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_err", err, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      run_op(16'h0001, 16'h0001, 4'd0, 16'h0002, 1'b0, 2, 1'b0);

      repeat (3) @(negedge clock);
      chk("scoreboard_empty", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/calc_ctrl.md
CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 Parameters: none; operand and result width SHALL be fixed at 16 bits, with the output serialized as 2 bytes.
REQ-002 clock  input  1  single system clock, rising-edge active.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse requesting an operation on num1/num2/op.
REQ-005 num1  input  16  operand A.
REQ-006 num2  input  16  operand B.
REQ-007 op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 DIV, 7 MOD; 8-15 illegal.
REQ-008 out_ready  input  1  sink accepts the out byte this cycle.
REQ-009 out  output  8  result byte.
REQ-010 out_valid  output  1  out holds a valid byte.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 err  output  1  error flag for the current result, valid while out_valid=1.
REQ-013 done  output  1  one-cycle pulse on acceptance of the low byte.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, ITER, OUT_HI and OUT_LO.
REQ-015 IDLE with start=1 SHALL latch num1, num2 and op into internal registers on that edge; start SHALL be ignored in all other states.
REQ-016 IDLE->EXEC SHALL occur for ops 0-4; IDLE->ITER for op 5, and for ops 6/7 when num2!=0; IDLE->OUT_HI for illegal ops and for DIV/MOD with num2==0.
REQ-017 EXEC SHALL last 1 cycle, register the result (ADD/SUB modulo 2^16, bitwise ops), then go to OUT_HI.
REQ-018 ITER SHALL last exactly 16 cycles using a 4-bit counter 0..15, then go to OUT_HI.
REQ-019 MUL SHALL use shift-add, one multiplier bit per cycle, producing the low 16 bits of A*B; overflow SHALL be discarded with err=0.
REQ-020 DIV/MOD SHALL use restoring division, one quotient bit per cycle, MSB first; DIV returns the quotient and MOD returns the remainder (unsigned).
REQ-021 Divide by zero SHALL set result=16'hFFFF and err=1; an illegal op SHALL set result=16'h0000 and err=1; in both cases datapath registers SHALL NOT change.
REQ-022 OUT_HI SHALL drive out=result[15:8] with out_valid=1, and hold until out_ready=1, then go to OUT_LO.
REQ-023 OUT_LO SHALL drive out=result[7:0] with out_valid=1, and hold until out_ready=1; on acceptance it SHALL pulse done=1 for that cycle and go to IDLE.
REQ-024 out and err SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 Latency with out_ready held at 1 SHALL be: start sampled at edge k; ALU ops give first out_valid in cycle k+2; MUL/DIV/MOD give it in cycle k+17; error cases give it in cycle k+1.
REQ-026 out SHALL be 8'h00 whenever out_valid=0.
REQ-027 A new start in the same cycle as done SHALL be ignored, because the state is still OUT_LO; the next start is accepted only from IDLE.

Reset
REQ-028 reset=0 SHALL asynchronously force state=IDLE, counter=0, operand/result registers=0, out=0, out_valid=0, busy=0, err=0, done=0.
REQ-029 Reset asserted mid-ITER or mid-OUT SHALL abort the operation; no done SHALL follow it.
REQ-030 After reset deasserts, the first start SHALL be accepted on the first rising edge.

Verification
REQ-031 ADD num1=16'h1234, num2=16'h0FF0, out_ready=1 -> out 8'h22 then 8'h24, err=0, done on the second byte, first byte at k+2.
REQ-032 MUL 16'h0123*16'h0010 -> 16'h1230 at k+17; MUL 16'hFFFF*16'h0002 -> 16'hFFFE, err=0.
REQ-033 DIV 16'h0064/16'h0007 -> 16'h000E; MOD with the same operands -> 16'h0002; DIV 16'h1234/16'h0000 -> 16'hFFFF, err=1 at k+1.
REQ-034 Illegal op 4'hA -> 16'h0000, err=1; a start pulse during ITER is ignored and the original result is delivered unchanged.
REQ-035 Backpressure: out_ready=0 for 5 cycles in OUT_HI -> out=8'h22 held stable, busy=1, no done; out_ready=1 then completes normally.
REQ-036 reset=0 asserted at ITER count 7 -> all outputs 0 immediately; a fresh ADD 16'h0001+16'h0001 -> 8'h00, 8'h02.
